rtc_set_ctrl: RTL and testbench

//  Time-set sequencer for the HH:MM:SS clock datapath.
//  - Debounces two raw buttons (MODE, INC) and steps a field-select FSM: RUN -> SET_HR -> SET_MIN -> SET_SEC.
//  - Issues per-field increment pulses to the hour/minute/second counters, with auto-repeat.
//  - Gates 1 Hz counting and drives per-field blink blanking to the 7-segment decoders.

---
 rtl/rtc_set_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rtc_set_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_set_ctrl.sv
// Time-set sequencer for the HH:MM:SS clock: debounces MODE/INC, walks the field-select FSM,
// issues per-field increment pulses with auto-repeat, and drives blink blanking.
module rtc_set_ctrl #(
    parameter int unsigned DB_MS      = 10,
    parameter int unsigned RPT_DLY_MS = 500,
    parameter int unsigned RPT_PER_MS = 100,
    parameter int unsigned BLINK_MS   = 250,
    parameter int unsigned TIMEOUT_MS = 30000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1k,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_en,
    output logic       presc_clr,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       inc_sec,
    output logic [2:0] blank,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    localparam logic [15:0] RPT_DLY_LAST = 16'(RPT_DLY_MS - 1);
    localparam logic [15:0] RPT_PER_LAST = 16'(RPT_PER_MS - 1);
    localparam logic [15:0] BLINK_LAST   = 16'(BLINK_MS - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_MS - 1);

    state_t           st;
    state_t           st_nxt;
    logic             mode_p0, mode_p1, inc_p0, inc_p1;
    logic [DB_MS-1:0] mode_sr, inc_sr;
    logic [DB_MS:0]   mode_sh, inc_sh;
    logic             mode_lvl, mode_lvl_d, inc_lvl, inc_lvl_d;
    logic [15:0]      to_cnt, rpt_cnt, blink_cnt;
    logic             rpt_armed, rpt_first, phase;
    logic             mode_press, inc_press, in_set, ev_inc, rpt_hit, rpt_fire, timeout, field_chg;

    function automatic logic db_level(input logic [DB_MS-1:0] sr, input logic cur);
        if (&sr)
            return 1'b1;
        else if (~|sr)
            return 1'b0;
        else
            return cur;
    endfunction

    function automatic state_t next_field(input state_t s);
        case (s)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            SET_MIN: return SET_SEC;
            default: return RUN;
        endcase
    endfunction

    always_comb begin
        mode_sh    = {mode_sr, mode_p1};
        inc_sh     = {inc_sr, inc_p1};
        mode_press = mode_lvl & ~mode_lvl_d;
        inc_press  = inc_lvl & ~inc_lvl_d;
        in_set     = (st != RUN);
        // MODE has priority: a coincident INC press is dropped and never arms repeat
        ev_inc     = in_set & inc_press & ~mode_press;
        rpt_hit    = rpt_first ? (rpt_cnt == RPT_DLY_LAST) : (rpt_cnt == RPT_PER_LAST);
        rpt_fire   = in_set & rpt_armed & inc_lvl & tick_1k & rpt_hit & ~mode_press;
        timeout    = in_set & tick_1k & (to_cnt == TIMEOUT_LAST) & ~mode_press & ~ev_inc & ~rpt_fire;
        field_chg  = mode_press | timeout;
        st_nxt     = st;
        if (mode_press)
            st_nxt = next_field(st);
        else if (timeout)
            st_nxt = RUN;
    end

    // Stage p0/p1: two-flop synchronizers, then tick-sampled debounce and edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_p0    <= 1'b0;
            mode_p1    <= 1'b0;
            inc_p0     <= 1'b0;
            inc_p1     <= 1'b0;
            mode_sr    <= '0;
            inc_sr     <= '0;
            mode_lvl   <= 1'b0;
            mode_lvl_d <= 1'b0;
            inc_lvl    <= 1'b0;
            inc_lvl_d  <= 1'b0;
        end else begin
            mode_p0    <= btn_mode;
            mode_p1    <= mode_p0;
            inc_p0     <= btn_inc;
            inc_p1     <= inc_p0;
            if (tick_1k) begin
                mode_sr <= mode_sh[DB_MS-1:0];
                inc_sr  <= inc_sh[DB_MS-1:0];
            end
            mode_lvl   <= db_level(mode_sr, mode_lvl);
            mode_lvl_d <= mode_lvl;
            inc_lvl    <= db_level(inc_sr, inc_lvl);
            inc_lvl_d  <= inc_lvl;
        end
    end

    // Field FSM, registered outputs and the timeout / repeat / blink counters
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= RUN;
            run_en    <= 1'b1;
            presc_clr <= 1'b0;
            inc_hr    <= 1'b0;
            inc_min   <= 1'b0;
            inc_sec   <= 1'b0;
            to_cnt    <= '0;
            rpt_cnt   <= '0;
            blink_cnt <= '0;
            rpt_armed <= 1'b0;
            rpt_first <= 1'b0;
            phase     <= 1'b0;
        end else begin
            st        <= st_nxt;
            run_en    <= (st_nxt == RUN);
            presc_clr <= in_set && (st_nxt == RUN);
            inc_hr    <= (ev_inc | rpt_fire) && (st == SET_HR);
            inc_min   <= (ev_inc | rpt_fire) && (st == SET_MIN);
            inc_sec   <= (ev_inc | rpt_fire) && (st == SET_SEC);
            if (field_chg) begin
                to_cnt    <= '0;
                blink_cnt <= '0;
                phase     <= 1'b0;
                rpt_armed <= 1'b0;
                rpt_cnt   <= '0;
            end else begin
                if (ev_inc || rpt_fire)
                    to_cnt <= '0;
                else if (in_set && tick_1k)
                    to_cnt <= to_cnt + 16'd1;
                if (in_set && tick_1k) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        phase     <= ~phase;
                    end else begin
                        blink_cnt <= blink_cnt + 16'd1;
                    end
                end
                if (ev_inc) begin
                    rpt_armed <= 1'b1;
                    rpt_first <= 1'b1;
                    rpt_cnt   <= '0;
                end else if (!inc_lvl) begin
                    rpt_armed <= 1'b0;
                    rpt_cnt   <= '0;
                end else if (rpt_armed && tick_1k) begin
                    if (rpt_hit) begin
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 16'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        blank = 3'b000;
        if (!inc_lvl) begin
            case (st)
                SET_HR:  blank = {phase, 2'b00};
                SET_MIN: blank = {1'b0, phase, 1'b0};
                SET_SEC: blank = {2'b00, phase};
                default: blank = 3'b000;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Bench for rtc_set_ctrl: directed button scenarios, a tick-level behavioural model checked
// every cycle, and literal expectations at the points of interest.
module tb_rtc_set_ctrl;
    localparam int DB   = 4;
    localparam int RDLY = 20;
    localparam int RPER = 5;
    localparam int BLNK = 8;
    localparam int TMO  = 100;
    localparam int TP   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1k = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       run_en, presc_clr, inc_hr, inc_min, inc_sec;
    logic [2:0] blank;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    rtc_set_ctrl #(
        .DB_MS(DB), .RPT_DLY_MS(RDLY), .RPT_PER_MS(RPER), .BLINK_MS(BLNK), .TIMEOUT_MS(TMO)
    ) dut (
        .clk(clk), .rst(rst), .tick_1k(tick_1k), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .run_en(run_en), .presc_clr(presc_clr), .inc_hr(inc_hr), .inc_min(inc_min),
        .inc_sec(inc_sec), .blank(blank), .state(state)
    );

    always #10 clk = ~clk;

    int tcnt = 0;
    always @(negedge clk) begin
        tcnt    = (tcnt + 1) % TP;
        tick_1k = (tcnt == 0);
    end

    // Behavioural model: debounce as run lengths of equal tick samples, repeat/blink/timeout
    // as elapsed tick counts measured from the press or field entry.
    logic       mv = 1'b0;
    logic       m_s0, m_s1, i_s0, i_s1, m_lvl, m_prev, i_lvl, i_prev;
    int         m_ones, m_zeros, i_ones, i_zeros;
    logic [1:0] e_st, ost;
    logic       e_run, e_presc, e_hr, e_min, e_sec;
    logic [2:0] e_blank;
    int         since_entry, idle, held;
    logic       armed, mp, ip, inset, evi, rpt, tmo, nm, ni;

    always @(posedge clk) begin
        if (rst) begin
            mv = 1'b1;
            m_s0 = 0; m_s1 = 0; i_s0 = 0; i_s1 = 0;
            m_ones = 0; m_zeros = DB; i_ones = 0; i_zeros = DB;
            m_lvl = 0; m_prev = 0; i_lvl = 0; i_prev = 0;
            e_st = 2'd0; e_run = 1; e_presc = 0; e_hr = 0; e_min = 0; e_sec = 0; e_blank = 3'b000;
            since_entry = 0; idle = 0; held = 0; armed = 0;
        end else begin
            mp    = m_lvl && !m_prev;
            ip    = i_lvl && !i_prev;
            ost   = e_st;
            inset = (ost != 2'd0);
            evi   = inset && ip && !mp;
            rpt   = inset && armed && i_lvl && tick_1k && !mp &&
                    (held + 1 >= RDLY) && (((held + 1 - RDLY) % RPER) == 0);
            tmo   = inset && tick_1k && !mp && !evi && !rpt && (idle + 1 >= TMO);
            e_hr  = (evi || rpt) && ost == 2'd1;
            e_min = (evi || rpt) && ost == 2'd2;
            e_sec = (evi || rpt) && ost == 2'd3;
            if (mp) e_st = ost + 2'd1;
            else if (tmo) e_st = 2'd0;
            e_presc = inset && (e_st == 2'd0);
            e_run   = (e_st == 2'd0);
            if (mp || tmo) begin
                since_entry = 0; idle = 0; armed = 0; held = 0;
            end else begin
                if (evi || rpt) idle = 0;
                else if (inset && tick_1k) idle++;
                if (inset && tick_1k) since_entry++;
                if (evi) begin armed = 1; held = 0; end
                else if (!i_lvl) armed = 0;
                else if (armed && tick_1k) held++;
            end
            nm = (m_ones >= DB) ? 1'b1 : (m_zeros >= DB) ? 1'b0 : m_lvl;
            ni = (i_ones >= DB) ? 1'b1 : (i_zeros >= DB) ? 1'b0 : i_lvl;
            m_prev = m_lvl; m_lvl = nm;
            i_prev = i_lvl; i_lvl = ni;
            if (tick_1k) begin
                if (m_s1) begin m_ones = (m_ones < DB) ? m_ones + 1 : DB; m_zeros = 0; end
                else begin m_zeros = (m_zeros < DB) ? m_zeros + 1 : DB; m_ones = 0; end
                if (i_s1) begin i_ones = (i_ones < DB) ? i_ones + 1 : DB; i_zeros = 0; end
                else begin i_zeros = (i_zeros < DB) ? i_zeros + 1 : DB; i_ones = 0; end
            end
            m_s1 = m_s0; m_s0 = btn_mode;
            i_s1 = i_s0; i_s0 = btn_inc;
            e_blank = 3'b000;
            if (!i_lvl && ((since_entry / BLNK) % 2 == 1)) begin
                case (e_st)
                    2'd1: e_blank = 3'b100;
                    2'd2: e_blank = 3'b010;
                    2'd3: e_blank = 3'b001;
                    default: e_blank = 3'b000;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            tests++;
            if ({state, run_en, presc_clr, inc_hr, inc_min, inc_sec, blank} !==
                {e_st, e_run, e_presc, e_hr, e_min, e_sec, e_blank}) begin
                fails++;
                if (fails <= 20)
                    $display("FAIL cycle_model t=%0t dut st=%0d run=%b clr=%b inc=%b%b%b blank=%b required st=%0d run=%b clr=%b inc=%b%b%b blank=%b",
                             $time, state, run_en, presc_clr, inc_hr, inc_min, inc_sec, blank,
                             e_st, e_run, e_presc, e_hr, e_min, e_sec, e_blank);
            end
        end
    end

    int cnt_hr = 0, cnt_min = 0, cnt_sec = 0, cnt_clr = 0, cnt_chg = 0;
    logic [1:0] prev_st = 2'd0;
    always @(posedge clk) begin
        #1;
        if (mv) begin
            cnt_hr  += int'(inc_hr);
            cnt_min += int'(inc_min);
            cnt_sec += int'(inc_sec);
            cnt_clr += int'(presc_clr);
            if (state !== prev_st) cnt_chg++;
        end
        prev_st = state;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        cnt_hr = 0; cnt_min = 0; cnt_sec = 0; cnt_clr = 0; cnt_chg = 0;
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (!tick_1k) @(posedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", int'(state), 0);
        check("reset_run_en", int'(run_en), 1);
        check("reset_presc_clr", int'(presc_clr), 0);
        check("reset_blank", int'(blank), 0);
        check("reset_inc", int'({inc_hr, inc_min, inc_sec}), 0);
        wait_ticks(1);

        // Bouncing MODE then a steady hold: one step into SET_HR
        clr_counts();
        btn_mode = 1; wait_ticks(1);
        btn_mode = 0; wait_ticks(1);
        btn_mode = 1; wait_ticks(1);
        wait_ticks(6);
        check("bounce_state", int'(state), 1);
        check("bounce_run_en", int'(run_en), 0);
        check("bounce_transitions", cnt_chg, 1);
        check("model_state_sethr", int'(e_st), 1);
        btn_mode = 0;

        // Blink in SET_HR: entry 3 ticks ago; phase flips every 8 ticks
        wait_ticks(1);
        check("blink_t4", int'(blank), 3'b000);
        wait_ticks(8);
        check("blink_t12", int'(blank), 3'b100);
        check("model_blink_t12", int'(e_blank), 3'b100);
        wait_ticks(3);
        check("blink_t15", int'(blank), 3'b100);
        wait_ticks(1);
        check("blink_t16", int'(blank), 3'b000);
        wait_ticks(12);
        check("blink_t28", int'(blank), 3'b100);

        // MODE and INC rise together in SET_HR, INC kept held
        clr_counts();
        btn_mode = 1; btn_inc = 1;
        wait_ticks(34);
        check("simul_state", int'(state), 2);
        check("simul_inc_pulses", cnt_hr + cnt_min + cnt_sec, 0);
        check("simul_transitions", cnt_chg, 1);
        btn_mode = 0; btn_inc = 0;
        wait_ticks(6);

        // INC held in SET_MIN: press pulse plus repeats at 20,25,30,35,40 ticks
        clr_counts();
        btn_inc = 1;
        wait_ticks(12);
        check("hold_blank", int'(blank), 0);
        wait_ticks(32);
        btn_inc = 0;
        wait_ticks(8);
        check("rpt_inc_min", cnt_min, 6);
        check("rpt_inc_hr", cnt_hr, 0);
        check("rpt_inc_sec", cnt_sec, 0);
        check("rpt_state", int'(state), 2);

        // Into SET_SEC, then idle until the timeout returns to RUN
        btn_mode = 1;
        wait_ticks(5);
        check("setsec_state", int'(state), 3);
        btn_mode = 0;
        clr_counts();
        wait_ticks(89);
        check("idle90_state", int'(state), 3);
        wait_ticks(9);
        check("idle99_state", int'(state), 3);
        check("idle99_clr", cnt_clr, 0);
        wait_ticks(1);
        check("timeout_state", int'(state), 0);
        check("timeout_run_en", int'(run_en), 1);
        check("timeout_clr_pulses", cnt_clr, 1);
        wait_ticks(2);
        check("timeout_clr_once", cnt_clr, 1);

        // INC press in RUN is ignored
        clr_counts();
        btn_inc = 1; wait_ticks(8);
        btn_inc = 0; wait_ticks(6);
        check("run_inc_pulses", cnt_hr + cnt_min + cnt_sec, 0);
        check("run_inc_state", int'(state), 0);
        check("run_inc_transitions", cnt_chg, 0);

        // Reset for one clk in SET_MIN with INC held
        btn_mode = 1; wait_ticks(5);
        btn_mode = 0; wait_ticks(5);
        btn_mode = 1; wait_ticks(5);
        btn_mode = 0; wait_ticks(5);
        check("pre_rst_state", int'(state), 2);
        btn_inc = 1;
        wait_ticks(6);
        clr_counts();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_state", int'(state), 0);
        check("rst_run_en", int'(run_en), 1);
        check("rst_pulses", int'({presc_clr, inc_hr, inc_min, inc_sec}), 0);
        wait_ticks(8);
        check("rst_clr_pulses", cnt_clr, 0);
        check("rst_inc_pulses", cnt_hr + cnt_min + cnt_sec, 0);
        check("rst_state_after", int'(state), 0);
        btn_inc = 0;
        wait_ticks(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
